simple_ram_wr_sched: RTL and testbench
======================================

Name: simple_ram_wr_sched

Overview:
- Write-port scheduler for simple_ram. It shares the RAM's single write port (wraddress/wren/data) between nreq independent requesters using round-robin arbitration.
- After reset, or on demand, it sequences a full-memory initialisation sweep. No requester ever drives the RAM write port directly.
- Sits between client write engines and the simple_ram instance. The RAM read port is untouched.

Parameters:
- width, 1, RAM data width in bits
- widthad, 4, RAM address width; depth = 2**widthad
- nreq, 4, number of write requesters (2..8)
- init_val, 0, width-bit value written to every word during initialisation

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- clear  input  1  pulse: re-run initialisation sweep
- req_valid  input  nreq  per-requester write request
- req_ready  output  nreq  per-requester grant/accept (combinational)
- req_addr  input  nreq*widthad  packed addresses, requester i at [i*widthad +: widthad]
- req_data  input  nreq*width  packed data, requester i at [i*width +: width]
- ram_wraddress  output  widthad  to simple_ram wraddress (registered)
- ram_wren  output  1  to simple_ram wren (registered)
- ram_data  output  width  to simple_ram data (registered)
- init_done  output  1  high when in RUN state (registered)

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values:
  - ram_wren=0, ram_wraddress=0, ram_data=0, init_done=0
  - state=INIT, init counter=0, round-robin pointer=0
- rst has priority over everything. Reset mid-sweep or mid-stream drops all in-flight activity, and the sweep restarts from address 0.
- States:
  - INIT: each cycle, register ram_wren=1, ram_wraddress=ctr, ram_data=init_val, then ctr++. The edge that registers address 2**widthad-1 also sets state=RUN and init_done=1.
  - Result: first init write is visible one edge after rst is released; init_done is high 2**widthad edges after release.
  - RUN: arbitrate. INIT→RUN is the only forward transition; RUN→INIT happens only on clear (or rst).
- req_ready:
  - All zero in INIT.
  - In RUN, at most one bit is high: the first valid requester searching from the pointer upward, wrapping modulo nreq.
  - A transfer occurs when req_valid[i] & req_ready[i].
  - req_ready must not depend on clear.
- On a transfer from requester i:
  - Next edge registers ram_wren=1 with that requester's address and data (latency 1 cycle).
  - Pointer becomes (i+1) mod nreq.
- RUN with no valid requester: ram_wren=0 next edge; ram_wraddress/ram_data hold last values; pointer unchanged.
- Throughput: one write per cycle, no bubbles between back-to-back grants.
- clear in RUN:
  - A transfer in the same cycle is still completed (written on the next edge).
  - The same edge sets state=INIT, ctr=0, init_done=0.
  - The init write for address 0 appears on the following edge.
- clear in INIT: restarts the sweep at ctr=0 (next write is address 0).
- Address collisions between requesters need no special handling: writes are serialised in grant order, and the last write wins.
- req_valid must remain asserted until accepted. A dropped valid is a client bug; no check is required.

Decomposition:
- Package simple_ram_sched_pkg: state enum typedef (ST_INIT, ST_RUN) and the nreq range bounds as localparams.
- One sub-module, rr_arbiter:
  - Inputs: nreq-bit request vector, pointer, enable.
  - Output: one-hot grant plus grant index.
  - Purely combinational.
- The scheduler owns the pointer, the FSM and the output registers.

Test Plan:
- Init sweep (width=1, widthad=4): assert rst 2 cycles, release → ram_wren=1 for exactly 16 consecutive cycles with addresses 0..15, data 0; init_done rises on the edge carrying address 15; req_ready=0 throughout even with all req_valid=1.
- Single write: after init, req_valid=4'b0100, req_addr[2]=5, data=1 → req_ready=4'b0100 the same cycle; next cycle ram_wren=1, ram_wraddress=5, ram_data=1; following cycle ram_wren=0, address still 5.
- Saturation: all four valid, each holding a distinct address, for 8 cycles → grant order 0,1,2,3,0,1,2,3, one per cycle; RAM addresses follow the same order with no idle cycles.
- Fairness: after a grant to requester 3, present only req_valid=4'b1010 → requester 1 is granted, then requester 3, then requester 1.
- clear mid-stream: clear=1 in the same cycle requester 0 is granted at addr 9 → next edge writes addr 9; init_done falls; the next 16 edges write addresses 0..15 with init_val; req_ready=0 until init_done is high again.
- Reset mid-sweep: assert rst when ram_wraddress=7 → ram_wren=0 while rst is high; after release the sweep restarts at address 0 and completes all 16 words.

Source files
------------

// File: rtl/simple_ram_sched_pkg.sv
// Shared types for the simple_ram write-port scheduler.
// State encoding and legal requester-count bounds.
package simple_ram_sched_pkg;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  localparam int NREQ_MIN = 2;
  localparam int NREQ_MAX = 8;

endpackage

// File: rtl/simple_ram_wr_sched_rr_arbiter.sv
// Round-robin arbiter: first request at or above ptr, wrapping.
// Purely combinational, one-hot grant plus its index.
module rr_arbiter #(
  parameter  int nreq = 4,
  localparam int iw   = (nreq > 1) ? $clog2(nreq) : 1
) (
  input  logic [nreq-1:0] req,
  input  logic [iw-1:0]   ptr,
  input  logic            en,
  output logic [nreq-1:0] gnt,
  output logic [iw-1:0]   idx
);

  logic found;
  int   j;

  // scan from the pointer upward, keep the first hit
  always_comb begin
    found = 1'b0;
    j     = 0;
    gnt   = '0;
    idx   = '0;
    for (int k = 0; k < nreq; k++) begin
      j = (int'(ptr) + k) % nreq;
      if (en && !found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = iw'(j);
      end
    end
  end

endmodule

// File: rtl/simple_ram_wr_sched.sv
// Shares the simple_ram write port between nreq requesters.
// Runs an init sweep after reset or clear, then round-robin.
module simple_ram_wr_sched
  import simple_ram_sched_pkg::*;
#(
  parameter int               width    = 1,
  parameter int               widthad  = 4,
  parameter int               nreq     = 4,
  parameter logic [width-1:0] init_val = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic [nreq-1:0]         req_valid,
  output logic [nreq-1:0]         req_ready,
  input  logic [nreq*widthad-1:0] req_addr,
  input  logic [nreq*width-1:0]   req_data,
  output logic [widthad-1:0]      ram_wraddress,
  output logic                    ram_wren,
  output logic [width-1:0]        ram_data,
  output logic                    init_done
);

  localparam int iw = (nreq > 1) ? $clog2(nreq) : 1;

  if (nreq < NREQ_MIN || nreq > NREQ_MAX) begin : g_bad_nreq
    $error("simple_ram_wr_sched: nreq out of range");
  end

  state_t             state_q, state_d;
  logic [widthad-1:0] ctr_q, ctr_d;
  logic [iw-1:0]      ptr_q, ptr_d;
  logic [widthad-1:0] addr_d;
  logic [width-1:0]   data_d;
  logic               wren_d;
  logic               done_d;
  logic [nreq-1:0]    gnt;
  logic [iw-1:0]      gidx;
  logic               xfer;

  rr_arbiter #(
    .nreq(nreq)
  ) u_arb (
    .req (req_valid),
    .ptr (ptr_q),
    .en  (state_q == ST_RUN),
    .gnt (gnt),
    .idx (gidx)
  );

  assign req_ready = gnt;
  assign xfer      = |gnt;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_INIT;
    else     state_q <= state_d;
  end

  // next state, sweep counter, pointer and RAM write fields
  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    ptr_d   = ptr_q;
    wren_d  = 1'b0;
    addr_d  = ram_wraddress;
    data_d  = ram_data;
    done_d  = init_done;
    unique case (state_q)
      ST_INIT: begin
        if (clear) begin
          ctr_d = '0;
        end else begin
          wren_d = 1'b1;
          addr_d = ctr_q;
          data_d = init_val;
          ctr_d  = ctr_q + 1'b1;
          if (&ctr_q) begin
            state_d = ST_RUN;
            done_d  = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (xfer) begin
          wren_d = 1'b1;
          addr_d = req_addr[int'(gidx)*widthad +: widthad];
          data_d = req_data[int'(gidx)*width +: width];
          if (int'(gidx) == nreq - 1) ptr_d = '0;
          else                        ptr_d = gidx + 1'b1;
        end
        if (clear) begin
          state_d = ST_INIT;
          ctr_d   = '0;
          done_d  = 1'b0;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // registered write port, counter and pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      ctr_q         <= '0;
      ptr_q         <= '0;
      ram_wren      <= 1'b0;
      ram_wraddress <= '0;
      ram_data      <= '0;
      init_done     <= 1'b0;
    end else begin
      ctr_q         <= ctr_d;
      ptr_q         <= ptr_d;
      ram_wren      <= wren_d;
      ram_wraddress <= addr_d;
      ram_data      <= data_d;
      init_done     <= done_d;
    end
  end

endmodule

// File: tb/tb_simple_ram_wr_sched.sv
// Randomized bench for simple_ram_wr_sched.
// Held requests, clears and resets against a scheduler model.
module tb_simple_ram_wr_sched;

  localparam int W   = 1;
  localparam int AW  = 4;
  localparam int N   = 4;
  localparam int DEP = 1 << AW;
  localparam logic [W-1:0] IV = 1'b0;

  logic            clk = 1'b0;
  logic            rst;
  logic            clear;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_addr;
  logic [N*W-1:0]  req_data;
  logic [AW-1:0]   ram_wraddress;
  logic            ram_wren;
  logic [W-1:0]    ram_data;
  logic            init_done;

  simple_ram_wr_sched #(
    .width   (W),
    .widthad (AW),
    .nreq    (N),
    .init_val(IV)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .ram_wraddress(ram_wraddress),
    .ram_wren     (ram_wren),
    .ram_data     (ram_data),
    .init_done    (init_done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t",
                  tag, got, exp, $time);
  endtask

  // client side: held requests
  bit       pend [N];
  int       paddr[N];
  int       pdata[N];

  // model: mode, sweep position, rotation start, expected port
  bit       m_run;
  int       m_ctr;
  int       m_ptr;
  int       e_wren, e_addr, e_data, e_done;

  // first pending requester at or after m_ptr, or -1
  function automatic int pick();
    if (!m_run) return -1;
    for (int k = 0; k < N; k++)
      if (pend[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic drive(input int p_new,
                       input int p_clr,
                       input int p_rst);
    for (int i = 0; i < N; i++) begin
      if (!pend[i] && $urandom_range(99) < p_new) begin
        pend[i]  = 1'b1;
        paddr[i] = $urandom_range(DEP - 1);
        pdata[i] = $urandom_range((1 << W) - 1);
      end
      req_valid[i]           = pend[i];
      req_addr[i*AW +: AW]   = AW'(paddr[i]);
      req_data[i*W +: W]     = W'(pdata[i]);
    end
    clear = ($urandom_range(999) < p_clr);
    rst   = ($urandom_range(999) < p_rst);
  endtask

  // advance the model across one clock edge
  task automatic model_edge();
    int g;
    g = pick();
    if (g >= 0) pend[g] = 1'b0;
    if (rst) begin
      m_run = 0; m_ctr = 0; m_ptr = 0;
      e_wren = 0; e_addr = 0; e_data = 0; e_done = 0;
    end else if (!m_run) begin
      if (clear) begin
        m_ctr  = 0;
        e_wren = 0;
      end else begin
        e_wren = 1;
        e_addr = m_ctr;
        e_data = IV;
        if (m_ctr == DEP - 1) begin
          m_run  = 1;
          e_done = 1;
        end
        m_ctr = (m_ctr + 1) % DEP;
      end
    end else begin
      e_wren = 0;
      if (g >= 0) begin
        e_wren = 1;
        e_addr = paddr[g];
        e_data = pdata[g];
        m_ptr  = (g + 1) % N;
      end
      if (clear) begin
        m_run  = 0;
        m_ctr  = 0;
        e_done = 0;
      end
    end
  endtask

  task automatic cycle(input int p_new,
                       input int p_clr,
                       input int p_rst);
    int g;
    drive(p_new, p_clr, p_rst);
    #1;
    g = pick();
    chk("req_ready", 32'(req_ready),
        (g >= 0) ? (32'd1 << g) : 32'd0);
    model_edge();
    @(posedge clk);
    #1;
    chk("ram_wren", 32'(ram_wren), e_wren);
    chk("ram_wraddress", 32'(ram_wraddress), e_addr);
    chk("ram_data", 32'(ram_data), e_data);
    chk("init_done", 32'(init_done), e_done);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      pend[i] = 0; paddr[i] = 0; pdata[i] = 0;
    end
    m_run = 0; m_ctr = 0; m_ptr = 0;
    e_wren = 0; e_addr = 0; e_data = 0; e_done = 0;
    rst = 1; clear = 0;
    req_valid = '0; req_addr = '0; req_data = '0;
    @(negedge clk);
    // reset for two cycles, then sweep with all requesters waiting
    repeat (2) cycle(100, 0, 1000);
    repeat (40) cycle(100, 0, 0);
    repeat (300) cycle(30, 20, 0);
    repeat (300) cycle(70, 15, 10);
    repeat (200) cycle(10, 5, 3);
    repeat (100) cycle(100, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
